dco_tune_ctrl: RTL and testbench

Calibration and tracking controller for the ring-oscillator DCO. Drives the DCO's `CTW`, `FTW` and `enable` inputs, requests frequency measurements from the external DCO edge counter, and runs a coarse binary search, then a fine linear search, then continuous bang-bang tracking against a target count. Sits in the `clk_ref` domain between the loop-control logic and the DCO/counter pair.

---
 rtl/dco_ctrl_pkg.sv | 28 ++
 rtl/dco_meas_seq.sv | 80 ++++++++
 rtl/dco_tune_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dco_tune_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dco_ctrl_pkg.sv
// Shared types, limits and code helpers for the DCO tuning controller.
package dco_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COARSE,
    S_FINE,
    S_TRACK,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETTLE,
    P_WAIT
  } phase_t;

  localparam logic [3:0] CTW_MAX  = 4'd15;
  localparam logic [3:0] FINE_MAX = 4'd8;

  function automatic logic [7:0] therm8(input logic [3:0] n);
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) t[i] = (4'(i) < n);
    return t;
  endfunction

endpackage

// File: rtl/dco_meas_seq.sv
// Measurement sequencer: settle delay, meas_start pulse and
// meas_done timeout supervision.
module dco_meas_seq
  import dco_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             req,
  input  logic             abort,
  input  logic             meas_done,
  input  logic [CNT_W-1:0] meas_count,
  output logic             meas_start,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] count
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  phase_t        phase, phase_n;
  logic [SW-1:0] settle, settle_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          ms_n;

  // done beats timeout when both land on the same cycle
  assign done    = (phase == P_WAIT) && meas_done;
  assign timeout = (phase == P_WAIT) && !meas_done &&
                   (tcnt == TW'(TIMEOUT_CYC - 1));
  assign count   = meas_count;

  always_comb begin
    phase_n  = phase;
    settle_n = settle;
    tcnt_n   = tcnt;
    ms_n     = 1'b0;
    if (abort) begin
      phase_n = P_IDLE;
    end else if (req) begin
      phase_n  = P_SETTLE;
      settle_n = SW'(SETTLE_CYC - 1);
    end else begin
      case (phase)
        P_SETTLE: begin
          if (settle == '0) begin
            phase_n = P_WAIT;
            tcnt_n  = '0;
            ms_n    = 1'b1;
          end else begin
            settle_n = settle - SW'(1);
          end
        end
        P_WAIT: begin
          if (done || timeout) phase_n = P_IDLE;
          else tcnt_n = tcnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      phase      <= P_IDLE;
      settle     <= '0;
      tcnt       <= '0;
      meas_start <= 1'b0;
    end else begin
      phase      <= phase_n;
      settle     <= settle_n;
      tcnt       <= tcnt_n;
      meas_start <= ms_n;
    end
  end

endmodule

// File: rtl/dco_tune_ctrl.sv
// DCO calibration controller: coarse binary search, fine linear
// search, then bang-bang tracking around the latched target.
module dco_tune_ctrl
  import dco_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TOL         = 2,
  parameter int LOCK_CNT    = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] target,
  output logic             meas_start,
  input  logic             meas_done,
  input  logic [CNT_W-1:0] meas_count,
  output logic [7:0]       CTW,
  output logic [7:0]       FTW,
  output logic             enable,
  output logic             busy,
  output logic             locked,
  output logic             cal_err
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int HW = CNT_W + 1;

  state_t           state, state_n;
  logic [3:0]       ctw, ctw_n, n, n_n;
  logic [1:0]       bit_q, bit_n;
  logic [CNT_W-1:0] tgt, tgt_n, count, hi, lo;
  logic [HW-1:0]    hi_w;
  logic [LW-1:0]    inb, inb_n;
  logic [7:0]       ftw;
  logic             en_n, lock_n, err_n;
  logic             req, abort, done, timeout, fast, slow;

  assign hi_w = {1'b0, tgt} + HW'(TOL);
  assign hi   = hi_w[CNT_W] ? '1 : hi_w[CNT_W-1:0];
  assign lo   = (tgt < CNT_W'(TOL)) ? '0 : tgt - CNT_W'(TOL);
  assign fast = count > hi;
  assign slow = count < lo;
  assign CTW  = {4'b0000, ctw};
  assign FTW  = ftw;

  dco_meas_seq #(
    .CNT_W      (CNT_W),
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_seq (
    .clk_ref   (clk_ref),
    .rst       (rst),
    .req       (req),
    .abort     (abort),
    .meas_done (meas_done),
    .meas_count(meas_count),
    .meas_start(meas_start),
    .done      (done),
    .timeout   (timeout),
    .count     (count)
  );

  always_comb begin
    state_n = state;
    ctw_n   = ctw;
    n_n     = n;
    bit_n   = bit_q;
    tgt_n   = tgt;
    inb_n   = inb;
    en_n    = enable;
    lock_n  = locked;
    err_n   = cal_err;
    req     = 1'b0;
    abort   = 1'b0;
    if (stop) begin
      state_n = S_IDLE;
      en_n    = 1'b0;
      lock_n  = 1'b0;
      abort   = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            tgt_n   = target;
            err_n   = 1'b0;
            lock_n  = 1'b0;
            inb_n   = '0;
            ctw_n   = 4'd8;
            n_n     = 4'd0;
            bit_n   = 2'd3;
            en_n    = 1'b1;
            req     = 1'b1;
            state_n = S_COARSE;
          end
        end
        S_COARSE: begin
          if (done) begin
            req = 1'b1;
            if (count < tgt) ctw_n[bit_q] = 1'b0;
            if (bit_q == 2'd0) begin
              state_n = S_FINE;
              n_n     = 4'd0;
            end else begin
              ctw_n[bit_q - 2'd1] = 1'b1;
              bit_n = bit_q - 2'd1;
            end
          end
        end
        S_FINE: begin
          if (done) begin
            req = 1'b1;
            if (fast && n < FINE_MAX) n_n = n + 4'd1;
            else state_n = S_TRACK;
          end
        end
        S_TRACK: begin
          if (done) begin
            req = 1'b1;
            if (fast || slow) begin
              inb_n  = '0;
              lock_n = 1'b0;
              // at either end of the range the codes cannot move
              if ((fast && ctw == CTW_MAX && n == FINE_MAX) ||
                  (slow && ctw == 4'd0 && n == 4'd0)) begin
                err_n = 1'b1;
              end else if (fast) begin
                if (n == FINE_MAX) begin
                  ctw_n = ctw + 4'd1;
                  n_n   = 4'd0;
                end else begin
                  n_n = n + 4'd1;
                end
              end else begin
                if (n == 4'd0) begin
                  ctw_n = ctw - 4'd1;
                  n_n   = FINE_MAX;
                end else begin
                  n_n = n - 4'd1;
                end
              end
            end else begin
              if (inb != LW'(LOCK_CNT)) inb_n = inb + LW'(1);
              if (inb_n == LW'(LOCK_CNT)) lock_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (timeout) begin
        state_n = S_ERROR;
        err_n   = 1'b1;
        en_n    = 1'b0;
        lock_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state   <= S_IDLE;
      ctw     <= '0;
      n       <= '0;
      bit_q   <= '0;
      tgt     <= '0;
      inb     <= '0;
      ftw     <= '0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      locked  <= 1'b0;
      cal_err <= 1'b0;
    end else begin
      state   <= state_n;
      ctw     <= ctw_n;
      n       <= n_n;
      bit_q   <= bit_n;
      tgt     <= tgt_n;
      inb     <= inb_n;
      ftw     <= therm8(n_n);
      enable  <= en_n;
      busy    <= (state_n == S_COARSE) || (state_n == S_FINE) ||
                 (state_n == S_TRACK);
      locked  <= lock_n;
      cal_err <= err_n;
    end
  end

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Self-checking bench for dco_tune_ctrl: DCO/counter model plus a
// cycle-level behavioural reference of the controller.
module tb_dco_tune_ctrl;

  localparam int CNT_W  = 16;
  localparam int TOL    = 2;
  localparam int LCK    = 4;
  localparam int SETTLE = 8;
  localparam int TMO    = 1023;

  localparam int MI = 0, MC = 1, MF = 2, MT = 3, ME = 4;

  logic             clk_ref = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             meas_done = 1'b0;
  logic [CNT_W-1:0] target = '0;
  logic [CNT_W-1:0] meas_count = '0;
  logic             meas_start, enable, busy, locked, cal_err;
  logic [7:0]       CTW, FTW;

  always #5 clk_ref = ~clk_ref;

  dco_tune_ctrl #(
    .CNT_W(CNT_W), .TOL(TOL), .LOCK_CNT(LCK),
    .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_ref   (clk_ref),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .target    (target),
    .meas_start(meas_start),
    .meas_done (meas_done),
    .meas_count(meas_count),
    .CTW       (CTW),
    .FTW       (FTW),
    .enable    (enable),
    .busy      (busy),
    .locked    (locked),
    .cal_err   (cal_err)
  );

  int checks = 0;
  int failures = 0;
  int nprint = 0;

  // reference model state
  int m_mode = MI, m_ctw = 0, m_n = 0, m_tgt = 0;
  int m_inb = 0, m_bit = 0, m_kept = 0, m_phase = 0, m_el = 0;
  bit m_en = 0, m_lock = 0, m_err = 0, m_ms = 0, m_valid = 0;

  // stimulus state
  int shift = 0;
  int dly = 0;
  bit suppress = 0;
  bit stray_en = 0;
  int trials[$];

  function automatic int dco_count();
    int c;
    c = 200 + shift - 10 * m_ctw - m_n;
    if (c < 0) c = 0;
    if (c > 65535) c = 65535;
    return c;
  endfunction

  task automatic model_step();
    bit dn, to, fast, slow;
    int hi, lo, p, w;
    m_valid = 1;
    m_ms = 0;
    if (rst) begin
      m_mode = MI; m_ctw = 0; m_n = 0; m_en = 0;
      m_lock = 0; m_err = 0; m_phase = 0; m_el = 0; m_inb = 0;
      return;
    end
    hi = (m_tgt + TOL > 65535) ? 65535 : m_tgt + TOL;
    lo = (m_tgt - TOL < 0) ? 0 : m_tgt - TOL;
    w = m_el + 1;
    dn = (m_phase == 2) && meas_done;
    to = (m_phase == 2) && !meas_done && (w == TMO);
    fast = int'(meas_count) > hi;
    slow = int'(meas_count) < lo;
    if (stop) begin
      m_mode = MI; m_en = 0; m_lock = 0; m_phase = 0;
    end else if (start && (m_mode == MI || m_mode == ME)) begin
      m_tgt = int'(target); m_err = 0; m_lock = 0; m_inb = 0;
      m_ctw = 8; m_n = 0; m_kept = 0; m_bit = 3; m_en = 1;
      m_mode = MC; m_phase = 1; m_el = 0;
    end else if (dn) begin
      case (m_mode)
        MC: begin
          if (int'(meas_count) >= m_tgt) m_kept += (1 << m_bit);
          if (m_bit == 0) begin
            m_ctw = m_kept; m_n = 0; m_mode = MF;
          end else begin
            m_bit--;
            m_ctw = m_kept + (1 << m_bit);
          end
        end
        MF: begin
          if (fast && m_n < 8) m_n++;
          else m_mode = MT;
        end
        MT: begin
          // codes as one linear position: 9 fine steps per coarse step
          p = 9 * m_ctw + m_n;
          if (fast || slow) begin
            m_inb = 0; m_lock = 0;
            if ((fast && p == 143) || (slow && p == 0)) m_err = 1;
            else begin
              p = fast ? p + 1 : p - 1;
              m_ctw = p / 9; m_n = p % 9;
            end
          end else begin
            m_inb++;
            if (m_inb >= LCK) m_lock = 1;
          end
        end
        default: ;
      endcase
      m_phase = 1; m_el = 0;
    end else if (to) begin
      m_mode = ME; m_err = 1; m_en = 0; m_lock = 0; m_phase = 0;
    end else if (m_phase == 1) begin
      m_el++;
      if (m_el == SETTLE) begin
        m_ms = 1; m_phase = 2; m_el = 0;
      end
    end else if (m_phase == 2) begin
      m_el = w;
    end
  endtask

  always @(negedge clk_ref) begin
    logic [7:0] ec, ef;
    logic eb;
    if (m_valid) begin
      ec = 8'(m_ctw);
      ef = 8'((1 << m_n) - 1);
      eb = (m_mode == MC) || (m_mode == MF) || (m_mode == MT);
      checks++;
      if ({CTW, FTW, enable, busy, locked, cal_err, meas_start} !==
          {ec, ef, m_en, eb, m_lock, m_err, m_ms}) begin
        failures++;
        if (nprint < 30) begin
          nprint++;
          $display("FAIL outputs t=%0t got CTW=%h FTW=%h en=%b busy=%b lk=%b err=%b ms=%b want CTW=%h FTW=%h en=%b busy=%b lk=%b err=%b ms=%b",
                   $time, CTW, FTW, enable, busy, locked, cal_err,
                   meas_start, ec, ef, m_en, eb, m_lock, m_err, m_ms);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_ref);
    model_step();
    if (m_ms && m_mode == MC) trials.push_back(m_ctw);
    @(negedge clk_ref);
    start = 1'b0;
    stop = 1'b0;
    meas_done = 1'b0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        meas_done = 1'b1;
        meas_count = CNT_W'(dco_count());
      end
    end else if (stray_en && $urandom_range(0, 39) == 0) begin
      meas_done = 1'b1;
      meas_count = CNT_W'($urandom);
    end
    if (meas_start && !suppress) dly = $urandom_range(1, 6);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit cond(input int id);
    case (id)
      0: return m_lock;
      1: return !m_lock;
      2: return m_ctw == 8;
      3: return m_ctw == 7;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_until(input int id, input int budget, input string nm);
    int k;
    k = 0;
    while (!cond(id) && k < budget) begin
      tick();
      k++;
    end
    chk(nm, int'(cond(id)), 1);
  endtask

  initial begin
    int k;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ctw", int'(CTW), 0);
    chk("rst_ftw", int'(FTW), 0);
    chk("rst_en", int'(enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(cal_err), 0);

    // calibration to target 125
    target = 16'd125;
    start = 1'b1;
    tick();
    chk("start_busy", int'(busy), 1);
    chk("start_ctw", int'(CTW), 8);
    k = 0;
    while (!meas_start && k < 50) begin
      tick();
      k++;
    end
    chk("settle_latency", k, SETTLE);
    run_until(0, 1000, "lock1_reached");
    chk("trial_n", trials.size(), 4);
    chk("trial0", trials.size() > 0 ? trials[0] : -1, 8);
    chk("trial1", trials.size() > 1 ? trials[1] : -1, 4);
    chk("trial2", trials.size() > 2 ? trials[2] : -1, 6);
    chk("trial3", trials.size() > 3 ? trials[3] : -1, 7);
    chk("cal_ctw", int'(CTW), 7);
    chk("cal_ftw", int'(FTW), 8'h07);
    chk("cal_lock", int'(locked), 1);

    // model shifts by +5: n walks up to 8
    shift = 5;
    run_until(1, 300, "unlock_seen");
    chk("unlock", int'(locked), 0);
    run_until(0, 1000, "relock_reached");
    chk("relock_ctw", int'(CTW), 7);
    chk("relock_ftw", int'(FTW), 8'hFF);

    // fast at n=8 wraps into the next coarse step
    shift = 11;
    run_until(2, 500, "wrap_up_seen");
    chk("wrap_up_ctw", int'(CTW), 8);
    chk("wrap_up_ftw", int'(FTW), 8'h00);
    shift = 0;
    run_until(3, 500, "wrap_dn_seen");
    chk("wrap_dn_ctw", int'(CTW), 7);
    chk("wrap_dn_ftw", int'(FTW), 8'hFF);

    // start while busy has no effect
    target = 16'd50;
    start = 1'b1;
    tick();
    chk("busy_start_ctw", int'(CTW), 7);

    // reset mid-track
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ctw", int'(CTW), 0);
    chk("mrst_ftw", int'(FTW), 0);
    chk("mrst_en", int'(enable), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_lock", int'(locked), 0);

    // stop mid-coarse: second trial CTW=4 is held
    target = 16'd125;
    start = 1'b1;
    tick();
    repeat (16) tick();
    stop = 1'b1;
    tick();
    chk("stop_ctw", int'(CTW), 4);
    chk("stop_en", int'(enable), 0);
    chk("stop_busy", int'(busy), 0);

    // timeout
    suppress = 1'b1;
    start = 1'b1;
    tick();
    k = 0;
    while (!meas_start && k < 50) begin
      tick();
      k++;
    end
    k = 0;
    while (!cal_err && k < 1100) begin
      tick();
      k++;
    end
    chk("timeout_len", k, TMO);
    chk("timeout_en", int'(enable), 0);
    chk("timeout_busy", int'(busy), 0);
    suppress = 1'b0;
    start = 1'b1;
    tick();
    chk("restart_err", int'(cal_err), 0);
    run_until(0, 1000, "lock2_reached");
    chk("recal_ctw", int'(CTW), 7);
    chk("recal_ftw", int'(FTW), 8'h07);

    // randomized runs, stray meas_done pulses, drifting model
    stray_en = 1'b1;
    for (int r = 0; r < 12; r++) begin
      target = CNT_W'($urandom_range(30, 220));
      shift = int'($urandom_range(0, 20)) - 10;
      stop = 1'b1;
      tick();
      start = 1'b1;
      if ($urandom_range(0, 3) == 0) stop = 1'b1;
      tick();
      if (m_mode == MI) begin
        start = 1'b1;
        tick();
      end
      repeat ($urandom_range(150, 500)) begin
        if ($urandom_range(0, 99) == 0) start = 1'b1;
        if ($urandom_range(0, 29) == 0)
          shift += int'($urandom_range(0, 6)) - 3;
        tick();
      end
    end
    stray_en = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
